// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one SEG-bit segment per stage, carry registered between stages,
// valid/ready handshake with global stall. Define PIPE_ADD_SUB_EN to add the 'sub' input.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             carryin,
`ifdef PIPE_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             carryout
);

   localparam int SEG = WIDTH / STAGES;

   logic             w_advance;
   logic [WIDTH-1:0] w_b0;
   logic             w_c0;

   // Subtraction is a two's-complement add: invert op2 and force the stage-0 carry.
   always_comb begin
      w_b0 = op2;
      w_c0 = carryin;
`ifdef PIPE_ADD_SUB_EN
      if (sub) begin
         w_b0 = ~op2;
         w_c0 = 1'b1;
      end
`endif
   end

   assign w_advance = out_ready | ~out_valid;
   assign in_ready  = w_advance & ~rst;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO   = k * SEG;
      localparam int DONE = (k + 1) * SEG;
      localparam int REM  = WIDTH - DONE;

      logic            r_v;
      logic            r_c;
      logic [DONE-1:0] r_sum;

      logic [SEG-1:0]  w_a;
      logic [SEG-1:0]  w_b;
      logic            w_ci;
      logic            w_vi;
      logic [SEG:0]    w_seg;
      logic [DONE-1:0] w_sum_next;

      if (k == 0) begin : g_first
         assign w_a        = op1[SEG-1:0];
         assign w_b        = w_b0[SEG-1:0];
         assign w_ci       = w_c0;
         assign w_vi       = in_valid;
         assign w_sum_next = w_seg[SEG-1:0];
      end else begin : g_next
         assign w_a        = g_stage[k-1].g_ops.r_a[SEG-1:0];
         assign w_b        = g_stage[k-1].g_ops.r_b[SEG-1:0];
         assign w_ci       = g_stage[k-1].r_c;
         assign w_vi       = g_stage[k-1].r_v;
         assign w_sum_next = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
      end

      assign w_seg = {1'b0, w_a} + {1'b0, w_b} + {{SEG{1'b0}}, w_ci};

      always_ff @(posedge clk) begin
         if (rst) begin
            r_v   <= 1'b0;
            r_c   <= 1'b0;
            r_sum <= '0;
         end else if (w_advance) begin
            r_v   <= w_vi;
            r_c   <= w_seg[SEG];
            r_sum <= w_sum_next;
         end
      end

      // Upper operand segments ride along until their stage consumes them.
      if (k < STAGES - 1) begin : g_ops
         logic [REM-1:0] r_a;
         logic [REM-1:0] r_b;
         logic [REM-1:0] w_a_up;
         logic [REM-1:0] w_b_up;

         if (k == 0) begin : g_src0
            assign w_a_up = op1[WIDTH-1:SEG];
            assign w_b_up = w_b0[WIDTH-1:SEG];
         end else begin : g_srcn
            assign w_a_up = g_stage[k-1].g_ops.r_a[WIDTH-LO-1:SEG];
            assign w_b_up = g_stage[k-1].g_ops.r_b[WIDTH-LO-1:SEG];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_advance) begin
               r_a <= w_a_up;
               r_b <= w_b_up;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_v;
   assign out_data  = g_stage[STAGES-1].r_sum;
   assign carryout  = g_stage[STAGES-1].r_c;

endmodule
